// File: rtl/filter_sample_sequencer.sv
// Sample-rate sequencer: tick -> ADC capture -> filter strobe -> settle -> registered band output.
// Optional feature macro SEQ_OVERRUN_CNT_EN adds a saturating overrun/ADC-error counter output.
`timescale 1ns/1ps

module filter_sample_sequencer #(
   parameter int SIZE     = 22,
   parameter int DIV      = 1000,
   parameter int FILT_LAT = 3,
   parameter int ADC_TMO  = 64
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_en,
   input  logic                   i_sel_valid,
   input  logic [1:0]             i_sel,
   input  logic                   i_adc_done,
   input  logic signed [SIZE-1:0] i_y_a,
   input  logic signed [SIZE-1:0] i_y_b,
   input  logic signed [SIZE-1:0] i_y_c,
   input  logic                   i_dout_ready,
   output logic                   o_adc_start,
   output logic                   o_filt_en,
   output logic signed [SIZE-1:0] o_dout,
   output logic                   o_dout_valid,
   output logic [1:0]             o_sel_cur,
   output logic                   o_busy,
   output logic                   o_overrun,
`ifdef SEQ_OVERRUN_CNT_EN
   output logic                   o_adc_err,
   output logic [15:0]            o_overrun_cnt
`else
   output logic                   o_adc_err
`endif
);

   localparam int TW = $clog2(DIV);
   localparam int AW = $clog2(ADC_TMO);
   localparam int LW = $clog2(FILT_LAT + 1);

   localparam logic [TW-1:0] TCNT_MAX    = TW'(DIV - 1);
   localparam logic [AW-1:0] TMO_MAX     = AW'(ADC_TMO - 1);
   localparam logic [LW-1:0] SETTLE_LOAD = LW'(FILT_LAT - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_START    = 3'd1;
   localparam logic [2:0] S_WAIT_ADC = 3'd2;
   localparam logic [2:0] S_FILTER   = 3'd3;
   localparam logic [2:0] S_SETTLE   = 3'd4;
   localparam logic [2:0] S_OUTPUT   = 3'd5;

   logic [TW-1:0]          r_tcnt;
   logic [2:0]             r_state;
   logic [2:0]             w_state_next;
   logic [AW-1:0]          r_tmo;
   logic [LW-1:0]          r_scnt;
   logic [1:0]             r_sel_pend;
   logic [1:0]             r_sel_cur;
   logic                   r_adc_start;
   logic                   r_filt_en;
   logic signed [SIZE-1:0] r_dout;
   logic                   r_dout_valid;
   logic                   r_busy;
   logic                   r_overrun;
   logic                   r_adc_err;

   logic                   w_tick;
   logic                   w_handshake;
   logic                   w_timeout;
   logic                   w_overrun;
   logic signed [SIZE-1:0] w_band;

   assign w_tick      = i_en && (r_tcnt == TCNT_MAX);
   assign w_handshake = (r_state == S_OUTPUT) && i_dout_ready;
   assign w_timeout   = (r_state == S_WAIT_ADC) && !i_adc_done && (r_tmo == TMO_MAX);
   // A tick is only consumed from IDLE or by an OUTPUT handshake that restarts in the same cycle.
   assign w_overrun   = w_tick && (r_state != S_IDLE) && !w_handshake;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:     if (w_tick) w_state_next = S_START;
         S_START:    w_state_next = S_WAIT_ADC;
         S_WAIT_ADC: begin
            if (i_adc_done)          w_state_next = S_FILTER;
            else if (r_tmo == TMO_MAX) w_state_next = S_IDLE;
         end
         S_FILTER:   w_state_next = S_SETTLE;
         S_SETTLE:   if (r_scnt == '0) w_state_next = S_OUTPUT;
         S_OUTPUT:   if (i_dout_ready) w_state_next = w_tick ? S_START : S_IDLE;
         default:    w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      case (r_sel_cur)
         2'd1:    w_band = i_y_b;
         2'd2:    w_band = i_y_c;
         default: w_band = i_y_a;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tcnt       <= '0;
         r_state      <= S_IDLE;
         r_tmo        <= '0;
         r_scnt       <= '0;
         r_sel_pend   <= 2'd0;
         r_sel_cur    <= 2'd0;
         r_adc_start  <= 1'b0;
         r_filt_en    <= 1'b0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_overrun    <= 1'b0;
         r_adc_err    <= 1'b0;
      end else begin
         if (!i_en || r_tcnt == TCNT_MAX) r_tcnt <= '0;
         else                             r_tcnt <= r_tcnt + TW'(1);

         r_state      <= w_state_next;
         r_adc_start  <= (w_state_next == S_START);
         r_filt_en    <= (w_state_next == S_FILTER);
         r_dout_valid <= (w_state_next == S_OUTPUT);
         r_busy       <= (w_state_next != S_IDLE);
         r_overrun    <= w_overrun;
         r_adc_err    <= w_timeout;

         if (r_state == S_START)         r_tmo <= '0;
         else if (r_state == S_WAIT_ADC) r_tmo <= r_tmo + AW'(1);

         if (r_state == S_FILTER)                       r_scnt <= SETTLE_LOAD;
         else if (r_state == S_SETTLE && r_scnt != '0)  r_scnt <= r_scnt - LW'(1);

         if (i_sel_valid && i_sel != 2'd3) r_sel_pend <= i_sel;
         // Band switches only here, so a sample in flight keeps the band it started with.
         if (r_state == S_FILTER) r_sel_cur <= r_sel_pend;

         if (r_state == S_SETTLE && r_scnt == '0) r_dout <= w_band;
      end
   end

`ifdef SEQ_OVERRUN_CNT_EN
   logic [15:0] r_ovr_cnt;
   logic [16:0] w_ovr_sum;

   assign w_ovr_sum = {1'b0, r_ovr_cnt} + 17'(w_overrun) + 17'(w_timeout);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)          r_ovr_cnt <= 16'h0000;
      else if (w_ovr_sum[16]) r_ovr_cnt <= 16'hFFFF;
      else                   r_ovr_cnt <= w_ovr_sum[15:0];
   end

   assign o_overrun_cnt = r_ovr_cnt;
`endif

   assign o_adc_start  = r_adc_start;
   assign o_filt_en    = r_filt_en;
   assign o_dout       = r_dout;
   assign o_dout_valid = r_dout_valid;
   assign o_sel_cur    = r_sel_cur;
   assign o_busy       = r_busy;
   assign o_overrun    = r_overrun;
   assign o_adc_err    = r_adc_err;

endmodule

// File: tb/tb_filter_sample_sequencer.sv
// Scenario bench for filter_sample_sequencer: ADC responder plus output scoreboard, one task per scenario.
`timescale 1ns/1ps

module tb_filter_sample_sequencer;

   localparam int SIZE     = 22;
   localparam int DIV      = 8;
   localparam int FILT_LAT = 3;
   localparam int ADC_TMO  = 16;

   logic clk = 1'b0;
   logic rst_n, en, sel_valid, adc_done, dout_ready;
   logic [1:0] sel;
   logic signed [SIZE-1:0] y_a, y_b, y_c, dout;
   logic adc_start, filt_en, dout_valid, busy, overrun, adc_err;
   logic [1:0] sel_cur;
`ifdef SEQ_OVERRUN_CNT_EN
   logic [15:0] overrun_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int n_start = 0, n_filt = 0, n_ovr = 0, n_err = 0, n_pop = 0;
   bit adc_auto = 1'b1;
   bit yc_fixed = 1'b0;
   logic [1:0] m_sel_pend = 2'd0;

   typedef struct {
      logic [SIZE-1:0] d;
      logic [1:0]      s;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   filter_sample_sequencer #(
      .SIZE(SIZE), .DIV(DIV), .FILT_LAT(FILT_LAT), .ADC_TMO(ADC_TMO)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_en         (en),
      .i_sel_valid  (sel_valid),
      .i_sel        (sel),
      .i_adc_done   (adc_done),
      .i_y_a        (y_a),
      .i_y_b        (y_b),
      .i_y_c        (y_c),
      .i_dout_ready (dout_ready),
      .o_adc_start  (adc_start),
      .o_filt_en    (filt_en),
      .o_dout       (dout),
      .o_dout_valid (dout_valid),
      .o_sel_cur    (sel_cur),
      .o_busy       (busy),
      .o_overrun    (overrun),
      .o_adc_err    (adc_err)
`ifdef SEQ_OVERRUN_CNT_EN
      ,.o_overrun_cnt(overrun_cnt)
`endif
   );

   // ADC responder (adc_done two cycles after adc_start), pulse counters and output scoreboard.
   initial begin : p_monitor
      int dly;
      logic [31:0] ra, rb, rc;
      exp_t e;
      dly = 0;
      adc_done = 1'b0;
      y_a = '0; y_b = '0; y_c = '0;
      forever begin
         @(negedge clk);
         adc_done = 1'b0;
         if (!rst_n) begin
            dly = 0;
            continue;
         end
         n_start += int'(adc_start);
         n_filt  += int'(filt_en);
         n_ovr   += int'(overrun);
         n_err   += int'(adc_err);
         if (dout_valid && dout_ready) begin
            checks++;
            n_pop++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_empty: dout=%h sel_cur=%0d delivered, required no sample", dout, sel_cur);
            end else begin
               e = sb_q.pop_front();
               if (dout !== e.d || sel_cur !== e.s) begin
                  errors++;
                  $display("FAIL sb_dout: got dout=%h sel_cur=%0d, required dout=%h sel_cur=%0d",
                           dout, sel_cur, e.d, e.s);
               end else begin
                  $display("sample %0d: dout=%h sel_cur=%0d", n_pop, dout, sel_cur);
               end
            end
         end
         if (dly > 0) begin
            dly--;
            if (dly == 0) begin
               ra = $urandom(); rb = $urandom(); rc = $urandom();
               y_a = ra[SIZE-1:0];
               y_b = rb[SIZE-1:0];
               y_c = yc_fixed ? 22'h3FFFFF : rc[SIZE-1:0];
               adc_done = 1'b1;
               case (m_sel_pend)
                  2'd1:    e.d = y_b;
                  2'd2:    e.d = y_c;
                  default: e.d = y_a;
               endcase
               e.s = m_sel_pend;
               sb_q.push_back(e);
            end
         end
         if (adc_start && adc_auto) dly = 2;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int first;
      repeat (3) cyc();
      checks++; if (adc_start !== 1'b0)  begin errors++; $display("FAIL reset_adc_start: got %b, required 0", adc_start); end
      checks++; if (filt_en !== 1'b0)    begin errors++; $display("FAIL reset_filt_en: got %b, required 0", filt_en); end
      checks++; if (dout !== '0)         begin errors++; $display("FAIL reset_dout: got %h, required 0", dout); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b, required 0", dout_valid); end
      checks++; if (sel_cur !== 2'd0)    begin errors++; $display("FAIL reset_sel_cur: got %0d, required 0", sel_cur); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      checks++; if ({overrun, adc_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b, required 00", {overrun, adc_err}); end
      rst_n = 1'b1;
      en = 1'b1;
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (adc_start === 1'b1) begin first = i; break; end
      end
      checks++;
      if (first != DIV) begin errors++; $display("FAIL reset_first_start: got cycle %0d, required %0d", first, DIV); end
      $display("reset: first adc_start after %0d cycles", first);
   endtask

   task automatic test_normal();
      int last, ovr0, ns, nf, nv;
      logic prev_dv;
      last = 0; ovr0 = n_ovr; ns = 0; nf = 0; nv = 0;
      prev_dv = dout_valid;
      for (int c = 1; c <= 40; c++) begin
         cyc();
         if (filt_en === 1'b1) begin
            nf++; checks++;
            if (c - last != 3) begin errors++; $display("FAIL normal_filt_en: at +%0d after adc_start, required +3", c - last); end
         end
         if (dout_valid === 1'b1 && prev_dv !== 1'b1) begin
            nv++; checks++;
            if (c - last != 7) begin errors++; $display("FAIL normal_dout_valid: at +%0d after adc_start, required +7", c - last); end
         end
         if (adc_start === 1'b1) begin
            ns++; checks++;
            if (c - last != DIV) begin errors++; $display("FAIL normal_period: adc_start spacing %0d, required %0d", c - last, DIV); end
            last = c;
         end
         prev_dv = dout_valid;
      end
      checks++;
      if (ns != 5 || nf != 5 || nv != 5) begin
         errors++; $display("FAIL normal_counts: starts=%0d filt=%0d valid=%0d, required 5/5/5", ns, nf, nv);
      end
      checks++;
      if (n_ovr != ovr0) begin errors++; $display("FAIL normal_overrun: %0d pulses, required 0", n_ovr - ovr0); end
   endtask

   task automatic test_sel();
      bit found;
      cyc();
      sel_valid = 1'b1; sel = 2'd2; m_sel_pend = 2'd2; yc_fixed = 1'b1;
      cyc();
      sel_valid = 1'b0; sel = 2'd0;
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (dout_valid === 1'b1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found || dout !== 22'h3FFFFF || sel_cur !== 2'd2) begin
         errors++; $display("FAIL sel_c: valid=%b dout=%h sel_cur=%0d, required 1/3fffff/2", found, dout, sel_cur);
      end
      sel_valid = 1'b1; sel = 2'd3;
      cyc();
      sel_valid = 1'b0; sel = 2'd0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (dout_valid === 1'b1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found || sel_cur !== 2'd2 || dout !== 22'h3FFFFF) begin
         errors++; $display("FAIL sel_reserved: valid=%b dout=%h sel_cur=%0d, required 1/3fffff/2", found, dout, sel_cur);
      end
      yc_fixed = 1'b0;
   endtask

   task automatic test_stall();
      int ovr0, filt0, bad;
      bit found;
      logic [SIZE-1:0] d0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (adc_start === 1'b1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL stall_start: no adc_start within 20 cycles"); end
      dout_ready = 1'b0;
      ovr0 = n_ovr; filt0 = n_filt; bad = 0; d0 = '0;
      for (int i = 1; i <= 19; i++) begin
         cyc();
         if (i == 7) d0 = dout;
         if (i >= 7 && (dout_valid !== 1'b1 || dout !== d0)) bad++;
      end
      cyc();
      if (dout_valid !== 1'b1 || dout !== d0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d cycles with dout not held, required 0", bad); end
      checks++;
      if (n_ovr - ovr0 != 2) begin errors++; $display("FAIL stall_overrun: %0d pulses, required 2", n_ovr - ovr0); end
      checks++;
      if (n_filt - filt0 != 1) begin errors++; $display("FAIL stall_filt_en: %0d strobes, required 1", n_filt - filt0); end
      dout_ready = 1'b1;
      cyc();
      checks++;
      if (dout_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL stall_release: dout_valid=%b busy=%b, required 0/0", dout_valid, busy);
      end
   endtask

   task automatic test_handshake_tick();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 24; i++) begin
         cyc();
         if (dout_valid === 1'b1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL hs_valid: no dout_valid within 24 cycles"); end
      cyc();
      checks++;
      if (adc_start !== 1'b1 || dout_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL hs_restart: adc_start=%b dout_valid=%b overrun=%b busy=%b, required 1/0/0/1",
                  adc_start, dout_valid, overrun, busy);
      end
`ifdef SEQ_OVERRUN_CNT_EN
      checks++;
      if (overrun_cnt !== 16'd2) begin errors++; $display("FAIL hs_overrun_cnt: got %0d, required 2", overrun_cnt); end
`endif
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (dout_valid === 1'b1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL hs_next_valid: no dout_valid within 12 cycles"); end
   endtask

   task automatic test_timeout();
      int filt0, k;
      bit found;
      adc_auto = 1'b0;
      filt0 = n_filt;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (adc_start === 1'b1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL tmo_start: no adc_start within 20 cycles"); end
      k = 0;
      found = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         cyc();
         if (adc_err === 1'b1) begin k = i; found = 1'b1; break; end
      end
      checks++;
      if (k != ADC_TMO + 1) begin errors++; $display("FAIL tmo_adc_err: at +%0d after adc_start, required +%0d", k, ADC_TMO + 1); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: busy=%b, required 0", busy); end
      checks++;
      if (n_filt != filt0 || filt_en !== 1'b0) begin errors++; $display("FAIL tmo_filt_en: %0d strobes, required 0", n_filt - filt0); end
`ifdef SEQ_OVERRUN_CNT_EN
      checks++;
      if (overrun_cnt !== 16'd5) begin errors++; $display("FAIL tmo_overrun_cnt: got %0d, required 5", overrun_cnt); end
`endif
      $display("timeout: adc_err at +%0d", k);
      adc_auto = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         k++;
         if (adc_start === 1'b1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found || k != 3 * DIV) begin errors++; $display("FAIL tmo_restart: adc_start at +%0d, required +%0d", k, 3 * DIV); end
      k = 0;
      found = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         if (dout_valid === 1'b1) begin k = i; found = 1'b1; break; end
      end
      checks++;
      if (k != 7) begin errors++; $display("FAIL tmo_restart_valid: dout_valid at +%0d, required +7", k); end
   endtask

   task automatic test_async_reset();
      int first;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (filt_en === 1'b1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL arst_filt_en: no filt_en within 20 cycles"); end
      cyc();
      checks++;
      if (sel_cur !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL arst_pre: sel_cur=%0d busy=%b, required 2/1", sel_cur, busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dout_valid !== 1'b0 || busy !== 1'b0 || sel_cur !== 2'd0 || dout !== '0) begin
         errors++;
         $display("FAIL arst_async: dout_valid=%b busy=%b sel_cur=%0d dout=%h, required 0/0/0/0",
                  dout_valid, busy, sel_cur, dout);
      end
      sb_q.delete();
      m_sel_pend = 2'd0;
      cyc();
      cyc();
`ifdef SEQ_OVERRUN_CNT_EN
      checks++;
      if (overrun_cnt !== 16'd0) begin errors++; $display("FAIL arst_overrun_cnt: got %0d, required 0", overrun_cnt); end
`endif
      rst_n = 1'b1;
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (adc_start === 1'b1) begin first = i; break; end
      end
      checks++;
      if (first != DIV) begin errors++; $display("FAIL arst_first_start: got cycle %0d, required %0d", first, DIV); end
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (dout_valid === 1'b1) begin found = 1'b1; break; end
      end
      cyc();
      checks++;
      if (!found || sb_q.size() != 0 || n_pop != 12) begin
         errors++;
         $display("FAIL final_scoreboard: valid=%b pending=%0d delivered=%0d, required 1/0/12", found, sb_q.size(), n_pop);
      end
   endtask

   initial begin : p_main
      rst_n = 1'b0;
      en = 1'b0;
      sel_valid = 1'b0;
      sel = 2'd0;
      dout_ready = 1'b1;
      test_reset();
      test_normal();
      test_sel();
      test_stall();
      test_handshake_tick();
      test_timeout();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/filter_sample_sequencer.md
# filter_sample_sequencer

Sample-rate scheduler for the band-pass filter chain, sitting between the serial ADC receiver, the `Paso_Banda` filter and the output path. It generates the sample tick, starts each ADC capture and waits for the received word. It then strobes the filter enable, waits out the filter latency, and latches the user-selected band output (A/B/C) into a registered output with a valid/ready handshake. It also detects sample overruns and ADC timeouts, so the filter is never clocked twice for one sample or with a stale word.

## Interface
- `SIZE`, 22, fixed-point word width (sign+pf+mag).
- `DIV`, 1000, clk cycles per sample period; ≥ 4.
- `FILT_LAT`, 3, cycles from `filt_en` to filter outputs valid; ≥ 1.
- `ADC_TMO`, 64, max cycles spent in WAIT_ADC before abort; ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; gates the sample tick.
- `sel_valid`  in  1  one-cycle strobe from keyboard decoder.
- `sel`  in  2  band request: 0=A, 1=B, 2=C, 3=reserved, ignored.
- `adc_done`  in  1  one-cycle pulse: receiver word ready.
- `y_a`, `y_b`, `y_c`  in  SIZE each  filter band outputs, signed.
- `dout_ready`  in  1  downstream accepts `dout`.
- `adc_start`  out  1  one-cycle capture request to receiver.
- `filt_en`  out  1  one-cycle filter advance strobe.
- `dout`  out  SIZE  latched selected band sample, signed.
- `dout_valid`  out  1  `dout` holds an unconsumed sample.
- `sel_cur`  out  2  band in effect for the current/last sample.
- `busy`  out  1  state ≠ IDLE.
- `overrun`  out  1  one-cycle pulse: tick dropped.
- `adc_err`  out  1  one-cycle pulse: ADC timeout abort.

## Operation
- Tick counter `tcnt` counts 0..DIV-1 while `en`=1 and wraps to 0. `tick`=1 when `tcnt`=DIV-1 and `en`=1. `en`=0 holds `tcnt` at 0. An in-flight sequence always completes.
- FSM states: IDLE, START, WAIT_ADC, FILTER, SETTLE, OUTPUT.
  - IDLE: `tick` → START.
  - START: `adc_start`=1 → WAIT_ADC. Clear timeout counter.
  - WAIT_ADC: `adc_done` → FILTER. Counter reaching ADC_TMO-1 without `adc_done` → IDLE, `adc_err` pulse, no `filt_en`.
  - FILTER: `filt_en`=1, `sel_cur` ← `sel_pend` → SETTLE. Load settle counter.
  - SETTLE: exactly FILT_LAT cycles, then → OUTPUT. `dout` ← y_a/y_b/y_c per `sel_cur`, `dout_valid` ← 1.
  - OUTPUT: hold `dout`/`dout_valid` until `dout_ready`=1. On handshake: `tick` same cycle → START, otherwise → IDLE.
- `tick` in any state other than IDLE, and not in OUTPUT with a handshake the same cycle: tick dropped, `overrun`=1 for that cycle, FSM unaffected.
- `sel_valid` with `sel`≠3 writes `sel_pend` in any state. `sel`=3 is ignored. The pending band is applied only at FILTER, so a sample never switches band mid-sequence.
- `adc_done` outside WAIT_ADC is ignored.
- No arithmetic on samples. `dout` is a bit-exact copy of the selected input, sign preserved.

## Timing
- All outputs registered. Reset values: `adc_start`=0, `filt_en`=0, `dout`=0, `dout_valid`=0, `sel_cur`=0 (A), `busy`=0, `overrun`=0, `adc_err`=0. Also `sel_pend`=0, `tcnt`=0, state IDLE.
- `tick` at cycle T → `adc_start` high at T+1.
- `adc_done` at cycle N → `filt_en` high at N+1 → `dout_valid` high at N+2+FILT_LAT.
- Handshake at cycle H → `dout_valid` low at H+1, unless the same-cycle tick restarts (START at H+1, `dout_valid` still low).
- Reset asserted mid-operation: all outputs and state return to reset values immediately (asynchronous). Release is sampled on the next clk.

## Configuration
- `SEQ_OVERRUN_CNT_EN` defined:
  - Adds output `overrun_cnt` (16 bits).
  - Increments on each `overrun` or `adc_err` pulse, saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: port and counter absent, all other behaviour identical.

## Test plan
- DIV=8, FILT_LAT=3, `en`=1, `adc_done` 2 cycles after `adc_start`, `dout_ready`=1 → `adc_start` every 8 cycles, `filt_en` 1 cycle after each `adc_done`, `dout_valid` 5 cycles after `adc_done`, no `overrun`.
- `sel_valid` with `sel`=2 during WAIT_ADC, y_c=22'h3FFFFF → that sample `sel_cur`=2, `dout`=22'h3FFFFF. `sel`=3 afterwards → `sel_cur` stays 2.
- `dout_ready`=0 for 20 cycles with DIV=8 → `dout` stable, `overrun` pulses at each tick (2 pulses), exactly one `filt_en` total.
- ADC_TMO=16, `adc_done` never asserted → `adc_err` pulse 16 cycles after entering WAIT_ADC, FSM IDLE, no `filt_en`, next tick restarts normally.
- `rst` low during SETTLE → `dout_valid`=0, `busy`=0, `sel_cur`=0 without waiting for a clk edge. After release, the first `adc_start` comes DIV cycles later.
- Handshake coincident with tick → START next cycle, no `overrun`. With `SEQ_OVERRUN_CNT_EN`, `overrun_cnt` unchanged; after the earlier stall test it reads 2.
